alu_muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the execute stage, directly downstream of the registered ALU-source select. It consumes the registered register-file operand A and the selected second operand (register data 2 or sign-extended immediate). It computes MULT/MULTU/DIV/DIVU into HI/LO over multiple cycles using a start/busy/done handshake, and the hazard logic stalls on Busy.

---
 rtl/alu_muldiv_unit.sv | 139 +++++++++++++
 tb/tb_alu_muldiv_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: 32 shift-add or restoring shift-subtract
// iterations on a shared accumulator, then a sign-fixup cycle that writes HI/LO.
module alu_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] Operand_A,
    input  logic [WIDTH-1:0] Operand_B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivByZero
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               op_div;
    logic               sign_res;
    logic               sign_rem;
    logic               dz;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_borrow;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;
    logic [WIDTH-1:0]   hi_fix, lo_fix;

    always_comb begin
        a_neg = Op[0] & Operand_A[WIDTH-1];
        b_neg = Op[0] & Operand_B[WIDTH-1];
        mag_a = a_neg ? -Operand_A : Operand_A;
        mag_b = b_neg ? -Operand_B : Operand_B;

        // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
        mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        div_shift  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff   = div_shift - {1'b0, opnd};
        div_borrow = div_shift < {1'b0, opnd};

        if (op_div)
            acc_next = {(div_borrow ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                        acc[WIDTH-2:0], ~div_borrow};
        else
            acc_next = {mul_sum, acc[WIDTH-1:1]};

        prod_fix = sign_res ? -acc : acc;
        q_fix    = sign_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_fix    = sign_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

        if (op_div) begin
            hi_fix = r_fix;
            lo_fix = q_fix;
        end else begin
            hi_fix = prod_fix[2*WIDTH-1:WIDTH];
            lo_fix = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            count     <= '0;
            acc       <= '0;
            opnd      <= '0;
            op_div    <= 1'b0;
            sign_res  <= 1'b0;
            sign_rem  <= 1'b0;
            dz        <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
            DivByZero <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        op_div    <= Op[1];
                        count     <= '0;
                        Busy      <= 1'b1;
                        DivByZero <= 1'b0;
                        if (Op[1] && (Operand_B == '0)) begin
                            // Zero signs so the FIX cycle passes the raw dividend and all-ones through
                            dz       <= 1'b1;
                            sign_res <= 1'b0;
                            sign_rem <= 1'b0;
                            opnd     <= '0;
                            acc      <= {Operand_A, {WIDTH{1'b1}}};
                            state    <= FIX;
                        end else begin
                            dz       <= 1'b0;
                            sign_res <= a_neg ^ b_neg;
                            sign_rem <= Op[1] & a_neg;
                            opnd     <= Op[1] ? mag_b : mag_a;
                            acc      <= {{WIDTH{1'b0}}, (Op[1] ? mag_a : mag_b)};
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    Hi        <= hi_fix;
                    Lo        <= lo_fix;
                    DivByZero <= dz;
                    Done      <= 1'b1;
                    Busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Scoreboard bench for alu_muldiv_unit: directed ops push expected HI/LO/flag and
// due cycle; a monitor pops and compares on every Done pulse.
module tb_alu_muldiv_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] Operand_A, Operand_B;
    logic        Busy, Done, DivByZero;
    logic [31:0] Hi, Lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;

    alu_muldiv_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op),
        .Operand_A(Operand_A), .Operand_B(Operand_B),
        .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo), .DivByZero(DivByZero)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: each Done pulse must match the oldest outstanding expectation
    always @(negedge Clk) begin
        if (!Rst && Done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi", {32'd0, Hi}, {32'd0, e.hi});
                chk("lo", {32'd0, Lo}, {32'd0, e.lo});
                chk("divbyzero", {63'd0, DivByZero}, {63'd0, e.dz});
                chk("latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic push(input logic [31:0] hi, input logic [31:0] lo, input logic dz, input int lat);
        exp_t e;
        e.hi = hi; e.lo = lo; e.dz = dz; e.due = cyc + 1 + lat;
        sb.push_back(e);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                          input int lat, output int busy_cnt);
        int n;
        @(negedge Clk);
        Op = op; Operand_A = a; Operand_B = b; Start = 1'b1;
        push(ehi, elo, edz, lat);
        @(negedge Clk);
        Start = 1'b0; Operand_A = ~a; Operand_B = ~b; Op = ~op;
        busy_cnt = 0;
        for (n = 0; n < 60; n++) begin
            if (Done) break;
            if (Busy) busy_cnt++;
            @(negedge Clk);
        end
        if (n == 60) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n;
        for (n = 0; n < 80 && sb.size() != 0; n++) @(negedge Clk);
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    initial begin
        int bc;
        int dc;
        int n;
        Rst = 1'b1; Start = 1'b0; Op = 2'b00; Operand_A = '0; Operand_B = '0;
        repeat (3) @(negedge Clk);
        chk("rst_busy", {63'd0, Busy}, 64'd0);
        chk("rst_done", {63'd0, Done}, 64'd0);
        chk("rst_hi", {32'd0, Hi}, 64'd0);
        chk("rst_lo", {32'd0, Lo}, 64'd0);
        chk("rst_dz", {63'd0, DivByZero}, 64'd0);
        Rst = 1'b0;

        // Busy must still be low while Start is first presented
        @(negedge Clk);
        Op = 2'b00; Operand_A = 32'hFFFFFFFF; Operand_B = 32'hFFFFFFFF; Start = 1'b1;
        #1 chk("busy_before_accept", {63'd0, Busy}, 64'd0);
        push(32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
        @(negedge Clk);
        Start = 1'b0;
        bc = 0;
        for (n = 0; n < 60; n++) begin
            if (Done) break;
            if (Busy) bc++;
            @(negedge Clk);
        end
        if (n == 60) chk("done_timeout", 64'd0, 64'd1);
        chk("busy_cycles", 64'(bc), 64'd33);
        chk("busy_at_done", {63'd0, Busy}, 64'd0);
        @(negedge Clk);
        chk("done_one_cycle", {63'd0, Done}, 64'd0);

        run_op(2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, bc);
        run_op(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33, bc);
        run_op(2'b01, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33, bc);
        run_op(2'b10, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0, 33, bc);
        run_op(2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, bc);
        run_op(2'b11, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33, bc);
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, bc);
        run_op(2'b10, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF, 1'b1, 1, bc);
        chk("dz_busy_cycles", 64'(bc), 64'd1);
        run_op(2'b11, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1, bc);

        // DivByZero clears on the accepting edge of the next op
        @(negedge Clk);
        Op = 2'b00; Operand_A = 32'd2; Operand_B = 32'd3; Start = 1'b1;
        push(32'd0, 32'd6, 1'b0, 33);
        @(negedge Clk);
        Start = 1'b0;
        chk("dz_clear_on_accept", {63'd0, DivByZero}, 64'd0);
        drain();

        // Start held high throughout: one result from first operands, next accepted in Done cycle
        @(negedge Clk);
        Op = 2'b00; Operand_A = 32'h00010000; Operand_B = 32'h00010000; Start = 1'b1;
        push(32'd1, 32'd0, 1'b0, 33);
        for (n = 0; n < 60; n++) begin
            @(negedge Clk);
            if (Done) break;
            Operand_A = 32'(n + 11); Operand_B = 32'(n + 5); Op = 2'(n);
        end
        if (n == 60) chk("held_timeout", 64'd0, 64'd1);
        Op = 2'b00; Operand_A = 32'd9; Operand_B = 32'd9;
        push(32'd0, 32'd81, 1'b0, 33);
        @(negedge Clk);
        Start = 1'b0;
        chk("b2b_busy", {63'd0, Busy}, 64'd1);
        drain();

        // Reset mid-operation aborts with no Done and clears Hi/Lo
        @(negedge Clk);
        Op = 2'b00; Operand_A = 32'd123; Operand_B = 32'd456; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (10) @(negedge Clk);
        dc = done_cnt;
        Rst = 1'b1;
        #1;
        chk("midrst_busy", {63'd0, Busy}, 64'd0);
        chk("midrst_hi", {32'd0, Hi}, 64'd0);
        chk("midrst_lo", {32'd0, Lo}, 64'd0);
        @(negedge Clk);
        Rst = 1'b0;
        repeat (45) @(negedge Clk);
        chk("midrst_no_done", 64'(done_cnt), 64'(dc));
        chk("midrst_idle", {63'd0, Busy}, 64'd0);

        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
